// File: rtl/vx_perf_counter_bank.sv
// vx_perf_counter_bank: bank of NUM_CTRS performance counters with snapshot shadows and a read port
//   clk, reset_n       clock, asynchronous active-low reset
//   enable, clear      global count enable, synchronous clear of live counters and ovf
//   inc_valid, inc_amt per-channel increment strobe and amount (channel i at [i*INC_WIDTH +: INC_WIDTH])
//   snap               copy live counters and ovf flags into the shadow registers
//   rd_req_*           read request (valid/ready/addr) addressing a shadowed channel
//   rd_rsp_*           read response (valid/ready/data/ovf), one cycle after acceptance
//   ovf                live sticky overflow flags
module vx_perf_counter_bank #(
  parameter int NUM_CTRS   = 8,
  parameter int CTR_WIDTH  = 44,
  parameter int INC_WIDTH  = 4,
  parameter int SATURATE   = 0,
  parameter int ADDR_WIDTH = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [NUM_CTRS-1:0]           inc_valid,
  input  logic [NUM_CTRS*INC_WIDTH-1:0] inc_amt,
  input  logic                          snap,
  input  logic                          rd_req_valid,
  output logic                          rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]         rd_req_addr,
  output logic                          rd_rsp_valid,
  output logic [CTR_WIDTH-1:0]          rd_rsp_data,
  output logic                          rd_rsp_ovf,
  input  logic                          rd_rsp_ready,
  output logic [NUM_CTRS-1:0]           ovf
);
  logic [CTR_WIDTH-1:0] ctr [NUM_CTRS];
  logic [CTR_WIDTH-1:0] shadow [NUM_CTRS];
  logic [NUM_CTRS-1:0]  shadow_ovf;
  logic [CTR_WIDTH:0]   sum [NUM_CTRS];
  logic                 accept;
  logic                 in_range;
  // one extra bit so the carry out of each channel is visible
  always_comb begin
    for (int i = 0; i < NUM_CTRS; i++)
      sum[i] = {1'b0, ctr[i]} + {{(CTR_WIDTH+1-INC_WIDTH){1'b0}}, inc_amt[i*INC_WIDTH +: INC_WIDTH]};
  end
  // snapshot takes pre-edge values, so it naturally excludes a same-cycle increment or clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctr        <= '{default: '0};
      shadow     <= '{default: '0};
      ovf        <= '0;
      shadow_ovf <= '0;
    end else begin
      if (snap) begin
        shadow     <= ctr;
        shadow_ovf <= ovf;
      end
      for (int i = 0; i < NUM_CTRS; i++)
        if (clear) begin
          ctr[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (enable && inc_valid[i]) begin
          ctr[i] <= (SATURATE != 0 && sum[i][CTR_WIDTH]) ? '1 : sum[i][CTR_WIDTH-1:0];
          ovf[i] <= ovf[i] | sum[i][CTR_WIDTH];
        end
    end
  assign rd_req_ready = ~rd_rsp_valid | rd_rsp_ready;
  assign accept       = rd_req_valid & rd_req_ready;
  assign in_range     = 32'(rd_req_addr) < NUM_CTRS;
  // response registers only load on acceptance, so they stay stable under backpressure
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_ovf   <= 1'b0;
    end else if (accept) begin
      rd_rsp_valid <= 1'b1;
      rd_rsp_data  <= in_range ? shadow[rd_req_addr] : '0;
      rd_rsp_ovf   <= in_range & shadow_ovf[rd_req_addr];
    end else if (rd_rsp_ready) begin
      rd_rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_vx_perf_counter_bank.sv
// tb_vx_perf_counter_bank: directed tests for wrap and saturate variants of the counter bank
module tb_vx_perf_counter_bank;
  localparam int N = 6, W = 8, IW = 4, AW = 3;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clear = 1'b0, snap = 1'b0;
  logic [N-1:0] inc_valid = '0;
  logic [N*IW-1:0] inc_amt = '0;
  logic rd_req_valid = 1'b0, rd_rsp_ready = 1'b1;
  logic [AW-1:0] rd_req_addr = '0;
  logic w_req_ready, w_rsp_valid, w_rsp_ovf, s_req_ready, s_rsp_valid, s_rsp_ovf;
  logic [W-1:0] w_rsp_data, s_rsp_data;
  logic [N-1:0] w_ovf, s_ovf;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  vx_perf_counter_bank #(.NUM_CTRS(N), .CTR_WIDTH(W), .INC_WIDTH(IW), .SATURATE(0)) dw (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .inc_valid(inc_valid),
    .inc_amt(inc_amt), .snap(snap), .rd_req_valid(rd_req_valid), .rd_req_ready(w_req_ready),
    .rd_req_addr(rd_req_addr), .rd_rsp_valid(w_rsp_valid), .rd_rsp_data(w_rsp_data),
    .rd_rsp_ovf(w_rsp_ovf), .rd_rsp_ready(rd_rsp_ready), .ovf(w_ovf));

  vx_perf_counter_bank #(.NUM_CTRS(N), .CTR_WIDTH(W), .INC_WIDTH(IW), .SATURATE(1)) ds (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .inc_valid(inc_valid),
    .inc_amt(inc_amt), .snap(snap), .rd_req_valid(rd_req_valid), .rd_req_ready(s_req_ready),
    .rd_req_addr(rd_req_addr), .rd_rsp_valid(s_rsp_valid), .rd_rsp_data(s_rsp_data),
    .rd_rsp_ovf(s_rsp_ovf), .rd_rsp_ready(rd_rsp_ready), .ovf(s_ovf));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_req_valid = 1'b1;
    rd_req_addr = a;
    step();
    rd_req_valid = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (w_rsp_valid !== 1'b0 || s_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b/%b want 0", w_rsp_valid, s_rsp_valid); else pass_cnt++;
    total++; if (w_req_ready !== 1'b1 || s_req_ready !== 1'b1) $display("FAIL reset_req_ready got %b/%b want 1", w_req_ready, s_req_ready); else pass_cnt++;
    total++; if (w_ovf !== '0 || w_rsp_data !== '0 || w_rsp_ovf !== 1'b0) $display("FAIL reset_outputs got ovf=%b data=%0d rovf=%b want 0", w_ovf, w_rsp_data, w_rsp_ovf); else pass_cnt++;
    #10 reset_n = 1'b1;
  endtask

  task automatic test_count();
    enable = 1'b1;
    inc_valid = 6'b000001;
    inc_amt[0 +: IW] = 4'd3;
    repeat (10) step();
    inc_valid = '0;
    do_snap();
    rd_req_valid = 1'b1;
    rd_req_addr = 3'd0;
    step();
    rd_req_valid = 1'b0;
    total++; if (w_rsp_valid !== 1'b1) $display("FAIL count_rsp_valid got %b want 1", w_rsp_valid); else pass_cnt++;
    total++; if (w_rsp_data !== 8'd30 || w_rsp_ovf !== 1'b0) $display("FAIL count_rsp_data got %0d/%b want 30/0", w_rsp_data, w_rsp_ovf); else pass_cnt++;
    total++; if (s_rsp_data !== 8'd30) $display("FAIL count_sat_data got %0d want 30", s_rsp_data); else pass_cnt++;
    step();
    total++; if (w_rsp_valid !== 1'b0) $display("FAIL count_rsp_drop got %b want 0", w_rsp_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    inc_valid = 6'b000010;
    inc_amt[IW +: IW] = 4'd15;
    repeat (16) step();
    inc_amt[IW +: IW] = 4'd10;
    step();
    total++; if (w_ovf !== 6'b000000) $display("FAIL ovf_before got %b want 000000", w_ovf); else pass_cnt++;
    step();
    total++; if (w_ovf !== 6'b000010 || s_ovf !== 6'b000010) $display("FAIL ovf_set got %b/%b want 000010", w_ovf, s_ovf); else pass_cnt++;
    step();
    total++; if (w_ovf !== 6'b000010) $display("FAIL ovf_sticky got %b want 000010", w_ovf); else pass_cnt++;
    inc_valid = '0;
    do_snap();
    rd(3'd1);
    total++; if (w_rsp_data !== 8'd14 || w_rsp_ovf !== 1'b1) $display("FAIL ovf_wrap_data got %0d/%b want 14/1", w_rsp_data, w_rsp_ovf); else pass_cnt++;
    total++; if (s_rsp_data !== 8'd255 || s_rsp_ovf !== 1'b1) $display("FAIL ovf_sat_data got %0d/%b want 255/1", s_rsp_data, s_rsp_ovf); else pass_cnt++;
  endtask

  task automatic test_clear_snap();
    inc_valid = 6'b000100;
    inc_amt[2*IW +: IW] = 4'd10;
    repeat (10) step();
    clear = 1'b1;
    snap = 1'b1;
    inc_amt[2*IW +: IW] = 4'd5;
    step();
    clear = 1'b0;
    snap = 1'b0;
    inc_valid = '0;
    total++; if (w_ovf !== '0 || s_ovf !== '0) $display("FAIL clear_ovf got %b/%b want 0", w_ovf, s_ovf); else pass_cnt++;
    rd(3'd2);
    total++; if (w_rsp_data !== 8'd100 || w_rsp_ovf !== 1'b0) $display("FAIL clear_shadow2 got %0d/%b want 100/0", w_rsp_data, w_rsp_ovf); else pass_cnt++;
    rd(3'd1);
    total++; if (w_rsp_data !== 8'd14 || w_rsp_ovf !== 1'b1 || s_rsp_data !== 8'd255) $display("FAIL clear_shadow1 got %0d/%b/%0d want 14/1/255", w_rsp_data, w_rsp_ovf, s_rsp_data); else pass_cnt++;
    do_snap();
    rd(3'd2);
    total++; if (w_rsp_data !== 8'd0) $display("FAIL clear_live2 got %0d want 0", w_rsp_data); else pass_cnt++;
    rd(3'd1);
    total++; if (w_rsp_data !== 8'd0 || w_rsp_ovf !== 1'b0 || s_rsp_data !== 8'd0) $display("FAIL clear_live1 got %0d/%b/%0d want 0/0/0", w_rsp_data, w_rsp_ovf, s_rsp_data); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    inc_valid = 6'b011000;
    inc_amt[3*IW +: IW] = 4'd7;
    inc_amt[4*IW +: IW] = 4'd9;
    step();
    inc_valid = '0;
    do_snap();
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr = 3'd3;
    step();
    rd_req_addr = 3'd4;
    total++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 8'd7) $display("FAIL bp_first got %b/%0d want 1/7", w_rsp_valid, w_rsp_data); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      inc_valid = (k == 0) ? 6'b001000 : 6'b000000;
      inc_amt[3*IW +: IW] = 4'd5;
      snap = (k == 1);
      step();
      total++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 8'd7 || w_req_ready !== 1'b0) $display("FAIL bp_hold%0d got v=%b d=%0d rdy=%b want 1/7/0", k, w_rsp_valid, w_rsp_data, w_req_ready); else pass_cnt++;
    end
    snap = 1'b0;
    rd_rsp_ready = 1'b1;
    #1;
    total++; if (w_req_ready !== 1'b1) $display("FAIL bp_ready got %b want 1", w_req_ready); else pass_cnt++;
    step();
    rd_req_valid = 1'b0;
    total++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 8'd9) $display("FAIL b2b_second got %b/%0d want 1/9", w_rsp_valid, w_rsp_data); else pass_cnt++;
    step();
    total++; if (w_rsp_valid !== 1'b0) $display("FAIL b2b_drop got %b want 0", w_rsp_valid); else pass_cnt++;
    rd(3'd3);
    total++; if (w_rsp_data !== 8'd12) $display("FAIL bp_snap_later got %0d want 12", w_rsp_data); else pass_cnt++;
  endtask

  task automatic test_oob_enable();
    rd(3'd6);
    total++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 8'd0 || w_rsp_ovf !== 1'b0) $display("FAIL oob6 got %b/%0d/%b want 1/0/0", w_rsp_valid, w_rsp_data, w_rsp_ovf); else pass_cnt++;
    rd(3'd7);
    total++; if (w_rsp_data !== 8'd0 || w_rsp_ovf !== 1'b0) $display("FAIL oob7 got %0d/%b want 0/0", w_rsp_data, w_rsp_ovf); else pass_cnt++;
    enable = 1'b0;
    inc_valid = '1;
    inc_amt = '1;
    repeat (3) step();
    inc_valid = '0;
    inc_amt = '0;
    enable = 1'b1;
    do_snap();
    rd(3'd3);
    total++; if (w_rsp_data !== 8'd12) $display("FAIL disabled3 got %0d want 12", w_rsp_data); else pass_cnt++;
    rd(3'd4);
    total++; if (w_rsp_data !== 8'd9 || w_ovf !== '0) $display("FAIL disabled4 got %0d/%b want 9/0", w_rsp_data, w_ovf); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    inc_valid = 6'b100001;
    inc_amt[0 +: IW] = 4'd1;
    inc_amt[5*IW +: IW] = 4'd15;
    repeat (18) step();
    total++; if (w_ovf !== 6'b100000 || s_ovf !== 6'b100000) $display("FAIL mid_ovf got %b/%b want 100000", w_ovf, s_ovf); else pass_cnt++;
    rd_rsp_ready = 1'b0;
    rd(3'd3);
    total++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 8'd12) $display("FAIL mid_pending got %b/%0d want 1/12", w_rsp_valid, w_rsp_data); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (w_rsp_valid !== 1'b0 || s_rsp_valid !== 1'b0 || w_req_ready !== 1'b1) $display("FAIL async_rsp got %b/%b/%b want 0/0/1", w_rsp_valid, s_rsp_valid, w_req_ready); else pass_cnt++;
    total++; if (w_ovf !== '0 || s_ovf !== '0 || w_rsp_data !== '0) $display("FAIL async_ovf got %b/%b/%0d want 0", w_ovf, s_ovf, w_rsp_data); else pass_cnt++;
    inc_valid = '0;
    rd_rsp_ready = 1'b1;
    #2 reset_n = 1'b1;
    do_snap();
    rd(3'd0);
    total++; if (w_rsp_data !== 8'd0) $display("FAIL async_ctr0 got %0d want 0", w_rsp_data); else pass_cnt++;
    rd(3'd5);
    total++; if (w_rsp_data !== 8'd0 || w_rsp_ovf !== 1'b0 || s_rsp_data !== 8'd0) $display("FAIL async_ctr5 got %0d/%b/%0d want 0/0/0", w_rsp_data, w_rsp_ovf, s_rsp_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_clear_snap();
    test_back_to_back();
    test_oob_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
